// File: rtl/polyeta_pack_pkg.sv
// Shared Dilithium constants and helpers for the eta-polynomial packer.
// Holds the FSM encoding and field-width arithmetic used by the top and the group encoder.
package polyeta_pack_pkg;

  localparam int N     = 256;
  localparam int ETA_2 = 2;
  localparam int ETA_4 = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int polyeta_packedbytes(input int eta);
    return (eta == ETA_4) ? 128 : 96;
  endfunction

  function automatic int field_width(input int eta);
    return (eta == ETA_4) ? 4 : 3;
  endfunction

endpackage

// File: rtl/polyeta_pack_if.sv
// Request/result bundle between the key-generation sequencer and the eta packer.
// rtr is a level request held until rts; rts stays high while linear_r/err are valid.
interface polyeta_pack_if #(
  parameter int PACKED_BYTES = 96
);
  logic                      rtr;
  logic [8191:0]             linear_a;
  logic [8*PACKED_BYTES-1:0] linear_r;
  logic                      rts;
  logic                      err;

  modport master (output rtr, linear_a, input linear_r, rts, err);
  modport slave  (input rtr, linear_a, output linear_r, rts, err);
endinterface

// File: rtl/polyeta_group_encoder.sv
// Combinational packer for one group of 8 coefficients: fields t = ETA - a, LSB-first.
// Also flags any coefficient outside [-ETA, ETA]; the field is still the truncated value.
module polyeta_group_encoder
  import polyeta_pack_pkg::*;
#(
  parameter int ETA = ETA_2
) (
  input  logic [255:0]                   coefs,
  output logic [8*field_width(ETA)-1:0] word,
  output logic                           viol
);

  localparam int           W     = field_width(ETA);
  localparam logic [W-1:0] ETA_W = W'(ETA);

  // Only the low W bits of the coefficient matter for the truncated difference.
  always_comb begin
    word = '0;
    viol = 1'b0;
    for (int k = 0; k < 8; k++) begin
      word[W*k +: W] = ETA_W - coefs[32*k +: W];
      if ($signed(coefs[32*k +: 32]) > ETA || $signed(coefs[32*k +: 32]) < -ETA)
        viol = 1'b1;
    end
  end

endmodule

// File: rtl/polyeta_pack.sv
// Sequential eta-polynomial packer: captures 256 coefficients, then packs one
// 8-coefficient group per cycle into linear_r and raises rts after 32 groups.
module polyeta_pack
  import polyeta_pack_pkg::*;
#(
  parameter int ETA          = ETA_2,
  parameter int PACKED_BYTES = polyeta_packedbytes(ETA)
) (
  input  logic               clock,
  input  logic               reset,
  polyeta_pack_if.slave      bus,
  output state_e             dbg_state,
  output logic [4:0]         dbg_ctr
);

  localparam int GW = 8 * field_width(ETA);

  state_e                    state_q, state_d;
  logic [4:0]                ctr_q, ctr_d;
  logic [8191:0]             a_q, a_d;
  logic [8*PACKED_BYTES-1:0] linear_r_q, linear_r_d;
  logic                      err_q, err_d;

  logic [GW-1:0]             grp_word;
  logic                      grp_viol;

  polyeta_group_encoder #(.ETA(ETA)) u_enc (
    .coefs (a_q[{ctr_q, 8'h00} +: 256]),
    .word  (grp_word),
    .viol  (grp_viol)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      a_q        <= '0;
      linear_r_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      a_q        <= a_d;
      linear_r_q <= linear_r_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    a_d        = a_q;
    linear_r_d = linear_r_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.rtr) begin
          a_d     = bus.linear_a;
          ctr_d   = '0;
          err_d   = 1'b0;
          state_d = ST_PACK;
        end
      end
      // rtr is deliberately ignored here so a started run always completes.
      ST_PACK: begin
        linear_r_d[GW*int'(ctr_q) +: GW] = grp_word;
        err_d = err_q | grp_viol;
        ctr_d = ctr_q + 5'd1;
        if (ctr_q == 5'd31) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.rtr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rts      = (state_q == ST_DONE);
  assign bus.err      = err_q;
  assign bus.linear_r = linear_r_q;
  assign dbg_state    = state_q;
  assign dbg_ctr      = ctr_q;

endmodule
